// File: rtl/ccb_config_loader.sv
// rtl/ccb_config_loader.sv - streams config words into a shadow register, range-checks the
// select fields and commits them to a connection block select vector with a cset strobe.
module ccb_config_loader #(
    parameter  int W          = 7,
    parameter  int CONTROLIN  = 3,
    parameter  int DW         = 4,
    localparam int SEL_PER_IN = $clog2(2 * W),
    localparam int CFG_BITS   = SEL_PER_IN * CONTROLIN,
    localparam int NWORDS     = (CFG_BITS + DW - 1) / DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DW-1:0]       din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [CFG_BITS-1:0] c,
    output logic                cset,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [7:0]          cfg_count
);

    localparam int CW = $clog2(NWORDS + 1);
    localparam logic [SEL_PER_IN:0] NCAND = (SEL_PER_IN + 1)'(2 * W);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

    state_t                 state;
    logic [CW-1:0]          wcnt;
    logic [NWORDS*DW-1:0]   shadow;
    logic                   any_bad;

    assign din_ready = (state == LOAD);
    assign busy      = (state != IDLE);

    // Fields index {west_in, east_in}; anything at or past 2W has no track behind it.
    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < CONTROLIN; i++) begin
            if ({1'b0, shadow[i*SEL_PER_IN +: SEL_PER_IN]} >= NCAND)
                any_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            shadow    <= '0;
            c         <= '0;
            cset      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cfg_count <= 8'd0;
        end else begin
            cset <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        wcnt   <= '0;
                        shadow <= '0;
                        err    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (din_valid) begin
                        for (int k = 0; k < NWORDS; k++) begin
                            if (wcnt == CW'(k))
                                shadow[k*DW +: DW] <= din;
                        end
                        if (wcnt == CW'(NWORDS - 1))
                            state <= CHECK;
                        else
                            wcnt <= wcnt + CW'(1);
                    end
                end
                CHECK: begin
                    done <= 1'b1;
                    if (any_bad) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else begin
                        state     <= COMMIT;
                        c         <= shadow[CFG_BITS-1:0];
                        cset      <= 1'b1;
                        cfg_count <= cfg_count + 8'd1;
                    end
                end
                COMMIT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccb_config_loader.sv
// tb/tb_ccb_config_loader.sv - randomized bench for ccb_config_loader against a
// word-list reference model of the load/check/commit rules.
module tb_ccb_config_loader;

    localparam int NW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [11:0] c;
    logic        cset;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  cfg_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] exp_c;
    int          exp_cnt;
    logic        exp_err;

    ccb_config_loader #(.W(7), .CONTROLIN(3), .DW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .c         (c),
        .cset      (cset),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cfg_count (cfg_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit has_illegal(input logic [11:0] v);
        for (int i = 0; i < 3; i++)
            if (((v >> (4 * i)) & 12'hF) >= 12'd14) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [11:0] rand_legal();
        logic [11:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            v = v | (12'($urandom_range(13)) << (4 * i));
        return v;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_c"},         c,         0);
        check({tag, "_cset"},      cset,      0);
        check({tag, "_din_ready"}, din_ready, 0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_err"},       err,       0);
        check({tag, "_cfg_count"}, cfg_count, 0);
    endtask

    // Drives one full load of value v; stall_pct is the chance of din_valid low per
    // LOAD cycle, poke_start drives stray start pulses during LOAD and COMMIT.
    task automatic do_load(input logic [11:0] v, input int stall_pct, input bit poke_start);
        int  acc;
        int  stalls;
        int  ci;
        bit  bad;
        @(negedge clk);
        start = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ci = 2;
        acc = 0;
        stalls = 0;
        while (acc < NW && ci < 300) begin
            check("busy_load", busy, 1);
            check("ready_load", din_ready, 1);
            din_valid = ($urandom_range(99) >= stall_pct);
            din = din_valid ? v[acc*4 +: 4] : 4'($urandom);
            start = poke_start ? 1'($urandom_range(1)) : 1'b0;
            #1;
            if (din_valid && din_ready) acc++;
            else stalls++;
            @(negedge clk);
            ci++;
        end
        din_valid = 1'b0;
        start = 1'b0;
        din = 4'($urandom);
        if (acc < NW) begin
            check("load_timeout", acc, NW);
            return;
        end
        check("check_busy", busy, 1);
        check("check_ready", din_ready, 0);
        check("check_cset", cset, 0);
        bad = has_illegal(v);
        @(negedge clk);
        ci++;
        check("done_pulse", done, 1);
        if (bad) begin
            exp_err = 1'b1;
            check("bad_cset", cset, 0);
            check("bad_busy", busy, 0);
        end else begin
            exp_c   = v;
            exp_cnt = (exp_cnt + 1) % 256;
            exp_err = 1'b0;
            check("commit_cset", cset, 1);
            check("commit_busy", busy, 1);
            check("latency", ci, NW + 3 + stalls);
            if (poke_start) start = 1'b1;
        end
        check("c_value", c, exp_c);
        check("cfg_count", cfg_count, exp_cnt);
        check("err", err, exp_err);
        @(negedge clk);
        start = 1'b0;
        check("post_cset", cset, 0);
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        check("post_c", c, exp_c);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        din = 4'h0;
        din_valid = 1'b0;
        exp_c = '0;
        exp_cnt = 0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        do_load(12'h0D5, 0, 1'b0);
        check("ctrl0_sel", c[3:0], 5);
        check("ctrl1_sel", c[7:4], 13);

        do_load(12'h2E1, 0, 1'b0);
        do_load(12'h3A7, 0, 1'b0);

        // words offered while IDLE must not be consumed or change anything
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din = 4'($urandom);
            #1;
            check("idle_ready", din_ready, 0);
            check("idle_busy", busy, 0);
            check("idle_c", c, exp_c);
        end
        din_valid = 1'b0;

        do_load(12'h543, 50, 1'b0);
        do_load(rand_legal(), 30, 1'b1);

        // reset after two accepted words
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            din_valid = 1'b1;
            din = 4'hF;
            @(negedge clk);
        end
        din_valid = 1'b0;
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        exp_c = '0;
        exp_cnt = 0;
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_load(12'h006, 0, 1'b0);
        for (int n = 0; n < 255; n++)
            do_load(rand_legal(), $urandom_range(1) ? 0 : 25, 1'($urandom_range(1)));
        check("wrap_count", cfg_count, 0);
        check("wrap_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ccb_config_loader.md
# ccb_config_loader

Configuration sequencer for one `control_connection_block`. It accepts a stream of configuration words over a valid/ready handshake and assembles them into the block's select vector `c`. It then checks that every select field addresses a real track, and commits the vector with a one-cycle `cset` pulse. It sits between the fabric configuration bus and each connection block, so `c` never changes mid-load and illegal selects never reach the mux.

## Interface
- `W`, 7: tracks per direction on the connection block; candidate set is 2W tracks, `{west_in, east_in}`.
- `CONTROLIN`, 3: number of control inputs (select fields).
- `DW`, 4: configuration word width.
- Derived `SEL_PER_IN` = $clog2(2W); `CFG_BITS` = SEL_PER_IN*CONTROLIN; `NWORDS` = ceil(CFG_BITS/DW).
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high.
- `start`  in  1  begin a new load; honoured only in IDLE.
- `din`  in  DW  configuration word.
- `din_valid`  in  1  `din` valid.
- `din_ready`  out  1  loader accepts a word this cycle.
- `c`  out  CFG_BITS  select vector to the connection block; field i = `c[i*SEL_PER_IN +: SEL_PER_IN]`.
- `cset`  out  1  commit strobe to the connection block.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse at the end of every load, good or bad.
- `err`  out  1  sticky: the last load contained an illegal field.
- `cfg_count`  out  8  number of successful commits, wraps modulo 256.

## Operation
- States: IDLE, LOAD, CHECK, COMMIT.
- IDLE → LOAD on `start`. Entering LOAD clears the word counter, the shadow register and `err`.
- LOAD: a word is accepted when `din_valid && din_ready`. Word k is written to shadow bits `[k*DW +: DW]`, LSB-first. Bits of the last word at or above `CFG_BITS` are discarded. After word NWORDS-1 is accepted, LOAD → CHECK.
- CHECK: a field is illegal if its value is ≥ 2W. If all fields are legal, CHECK → COMMIT. If any field is illegal, CHECK → IDLE, `err` is set and `c` is left unchanged.
- COMMIT: `c` is loaded from the shadow register on the edge entering COMMIT. `cfg_count` increments (255 → 0). COMMIT → IDLE unconditionally.
- `start` in any state other than IDLE is ignored. `start` in the COMMIT cycle is not queued.
- `din_valid` outside LOAD is ignored, and no word is consumed.
- When 2W is a power of two, no field can be illegal and `err` never sets.

## Timing
- Reset values: state IDLE, `c`=0, `cset`=0, `din_ready`=0, `busy`=0, `done`=0, `err`=0, `cfg_count`=0. Reset mid-load discards the shadow register and returns to IDLE immediately, asynchronously.
- `din_ready` = (state==LOAD), decoded combinationally from state. `start` sampled at edge t puts `din_ready` high from cycle t+1.
- Last word accepted at edge t: CHECK during cycle t+1.
  - Good path: COMMIT during cycle t+2, with new `c`, `cset`=1 and `done`=1 (all registered). IDLE at t+3. Back-to-back loads are possible with `start` in cycle t+3.
  - Error path: IDLE during cycle t+2, with `done`=1, `err`=1 and `cset`=0.
- `c` changes only on the edge entering COMMIT, and is stable for the whole COMMIT cycle.
- `cset` is never high outside COMMIT.
- Minimum load latency, from `start` to `cset`: NWORDS+3 cycles with no stalls. Each `din_valid`-low cycle in LOAD adds one cycle.

## Test plan
All scenarios use W=7, CONTROLIN=3, DW=4, so `CFG_BITS`=12 and NWORDS=3.
- Good load: `start`, then words 0x5, 0xD, 0x0 back-to-back → `c`=12'h0D5 and `cset`/`done` high for exactly one cycle, NWORDS+3 cycles after `start`. `cfg_count`=1, `err`=0. Driving the connection block with this `c` gives `control_input[0]`=candidate[5] and `control_input[1]`=candidate[13].
- Illegal field: after the good load, load 0x1, 0xE, 0x2 → `err`=1 and `done` pulses, `cset` stays 0, `c` stays 12'h0D5, `cfg_count` stays 1. A following legal load clears `err` and commits.
- Stalls: toggle `din_valid` with random gaps during a load of 0x3, 0x4, 0x5 → exactly 3 words are consumed and `c`=12'h543. Words presented outside LOAD have no effect.
- Reset mid-load: assert `rst` after 2 accepted words → all outputs return to their reset values immediately. A fresh load then commits correctly, with no leftover shadow bits.
- Busy/start: pulse `start` during LOAD and during COMMIT → no restart and no extra load. `busy` is high from `start`+1 through COMMIT.
- Counter wrap: 256 random legal loads → `cfg_count` reads 0, `err`=0, and `c` matches the last load every time.
